// File: rtl/portas_arbitro.sv
// Round-robin arbiter/sequencer sharing one portasLogicas gate unit between two
// requesters: latch the winner, drive a/b, wait the settle time, return the result.
module portas_arbitro #(
    parameter int LATENCIA = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       gnt1,
    output logic [2:0] pl_a,
    output logic [2:0] pl_b,
    input  logic [2:0] pl_s1,
    input  logic [2:0] pl_s2,
    input  logic [2:0] pl_s3,
    input  logic [2:0] pl_s4,
    input  logic [2:0] pl_s5,
    input  logic [2:0] pl_s6,
    input  logic [2:0] pl_s7,
    input  logic       pl_s8,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [2:0] resp_dado,
    input  logic       resp_ack,
    output logic       ocupado
);
    typedef enum logic [1:0] {OCIOSO, ESPERA, RESPOSTA} estado_t;

    estado_t    estado, estado_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] op_q, op_n;
    logic [2:0] pl_a_n, pl_b_n, resp_dado_n;
    logic       gnt0_n, gnt1_n, resp_valid_n, resp_id_n;
    logic       ultimo, ultimo_n;
    logic       vencedor;
    logic [2:0] saida;

    assign ocupado = (estado != OCIOSO);

    // On contention the requester that did not win last time goes first.
    assign vencedor = (req0 && req1) ? ~ultimo : req1;

    always_comb begin
        saida = 3'b000;
        case (op_q)
            3'd0:    saida = pl_s1;
            3'd1:    saida = pl_s2;
            3'd2:    saida = pl_s3;
            3'd3:    saida = pl_s4;
            3'd4:    saida = pl_s5;
            3'd5:    saida = pl_s6;
            3'd6:    saida = pl_s7;
            default: saida = {2'b00, pl_s8};
        endcase
    end

    always_comb begin
        estado_n     = estado;
        cnt_n        = cnt;
        op_n         = op_q;
        pl_a_n       = pl_a;
        pl_b_n       = pl_b;
        ultimo_n     = ultimo;
        gnt0_n       = 1'b0;
        gnt1_n       = 1'b0;
        resp_valid_n = resp_valid;
        resp_id_n    = resp_id;
        resp_dado_n  = resp_dado;
        case (estado)
            OCIOSO: begin
                if (req0 || req1) begin
                    op_n     = vencedor ? op1 : op0;
                    pl_a_n   = vencedor ? a1 : a0;
                    pl_b_n   = vencedor ? b1 : b0;
                    ultimo_n = vencedor;
                    gnt0_n   = ~vencedor;
                    gnt1_n   = vencedor;
                    cnt_n    = 4'(LATENCIA);
                    estado_n = ESPERA;
                end
            end
            ESPERA: begin
                // The counter runs down to zero, so the capture lands LATENCIA+1 edges after accept.
                if (cnt == 4'd0) begin
                    resp_dado_n  = saida;
                    resp_valid_n = 1'b1;
                    resp_id_n    = ultimo;
                    estado_n     = RESPOSTA;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESPOSTA: begin
                if (resp_ack) begin
                    resp_valid_n = 1'b0;
                    estado_n     = OCIOSO;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            cnt        <= 4'd0;
            op_q       <= 3'd0;
            pl_a       <= 3'd0;
            pl_b       <= 3'd0;
            ultimo     <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_dado  <= 3'd0;
        end else begin
            estado     <= estado_n;
            cnt        <= cnt_n;
            op_q       <= op_n;
            pl_a       <= pl_a_n;
            pl_b       <= pl_b_n;
            ultimo     <= ultimo_n;
            gnt0       <= gnt0_n;
            gnt1       <= gnt1_n;
            resp_valid <= resp_valid_n;
            resp_id    <= resp_id_n;
            resp_dado  <= resp_dado_n;
        end
    end
endmodule

// File: tb/tb_portas_arbitro.sv
// Directed bench for portas_arbitro: one instance with LATENCIA=1, one with LATENCIA=3,
// sharing stimulus; a behavioural gate unit closes the loop for each.
module tb_portas_arbitro;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, resp_ack = 1'b0;
    logic [2:0] op0 = '0, a0 = '0, b0 = '0, op1 = '0, a1 = '0, b1 = '0;
    logic sel3 = 1'b0;

    logic       g0_1, g1_1, v_1, id_1, oc_1, s8_1;
    logic [2:0] pa_1, pb_1, d_1;
    logic [2:0] s1_1, s2_1, s3_1, s4_1, s5_1, s6_1, s7_1;
    logic       g0_3, g1_3, v_3, id_3, oc_3, s8_3;
    logic [2:0] pa_3, pb_3, d_3;
    logic [2:0] s1_3, s2_3, s3_3, s4_3, s5_3, s6_3, s7_3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign s1_1 = pa_1 & pb_1;    assign s2_1 = pa_1 | pb_1;
    assign s3_1 = ~(pa_1 & pb_1); assign s4_1 = ~(pa_1 | pb_1);
    assign s5_1 = pa_1 ^ pb_1;    assign s6_1 = ~(pa_1 ^ pb_1);
    assign s7_1 = ~pa_1;          assign s8_1 = (pa_1 == pb_1);
    assign s1_3 = pa_3 & pb_3;    assign s2_3 = pa_3 | pb_3;
    assign s3_3 = ~(pa_3 & pb_3); assign s4_3 = ~(pa_3 | pb_3);
    assign s5_3 = pa_3 ^ pb_3;    assign s6_3 = ~(pa_3 ^ pb_3);
    assign s7_3 = ~pa_3;          assign s8_3 = (pa_3 == pb_3);

    portas_arbitro #(.LATENCIA(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(g0_1),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(g1_1),
        .pl_a(pa_1), .pl_b(pb_1),
        .pl_s1(s1_1), .pl_s2(s2_1), .pl_s3(s3_1), .pl_s4(s4_1),
        .pl_s5(s5_1), .pl_s6(s6_1), .pl_s7(s7_1), .pl_s8(s8_1),
        .resp_valid(v_1), .resp_id(id_1), .resp_dado(d_1),
        .resp_ack(resp_ack), .ocupado(oc_1)
    );

    portas_arbitro #(.LATENCIA(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(g0_3),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(g1_3),
        .pl_a(pa_3), .pl_b(pb_3),
        .pl_s1(s1_3), .pl_s2(s2_3), .pl_s3(s3_3), .pl_s4(s4_3),
        .pl_s5(s5_3), .pl_s6(s6_3), .pl_s7(s7_3), .pl_s8(s8_3),
        .resp_valid(v_3), .resp_id(id_3), .resp_dado(d_3),
        .resp_ack(resp_ack), .ocupado(oc_3)
    );

    // Observed view: the instance under test in the current step.
    logic       o_g0, o_g1, o_v, o_id, o_oc;
    logic [2:0] o_pa, o_pb, o_d;
    assign o_g0 = sel3 ? g0_3 : g0_1;
    assign o_g1 = sel3 ? g1_3 : g1_1;
    assign o_v  = sel3 ? v_3  : v_1;
    assign o_id = sel3 ? id_3 : id_1;
    assign o_oc = sel3 ? oc_3 : oc_1;
    assign o_pa = sel3 ? pa_3 : pa_1;
    assign o_pb = sel3 ? pb_3 : pb_1;
    assign o_d  = sel3 ? d_3  : d_1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_n();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Packs the full visible output state for compact checks.
    function automatic logic [7:0] outs();
        return {o_g0, o_g1, o_v, o_id, o_oc, o_d};
    endfunction

    // Single-requester transaction, checked edge by edge; acked immediately.
    task automatic txn(input string tag, input logic who, input logic [2:0] op,
                       input logic [2:0] a, input logic [2:0] b, input int lat,
                       input logic [2:0] exp);
        if (who) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        edge_n();
        chk({tag, "_gnt"}, {6'd0, o_g0, o_g1}, {6'd0, ~who, who});
        chk({tag, "_pl"}, {2'd0, o_pa, o_pb}, {2'd0, a, b});
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < lat; i++) begin
            edge_n();
            chk({tag, "_wait"}, {6'd0, o_v, o_oc}, 8'h01);
        end
        edge_n();
        chk({tag, "_resp"}, {4'd0, o_v, o_id, o_g0, o_g1}, {4'd0, 1'b1, who, 2'b00});
        chk({tag, "_dado"}, {5'd0, o_d}, {5'd0, exp});
        resp_ack = 1'b1;
        edge_n();
        resp_ack = 1'b0;
        chk({tag, "_ack"}, {6'd0, o_v, o_oc}, 8'h00);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_outs", outs(), 8'h00);
        chk("rst_pl", {2'd0, o_pa, o_pb}, 8'h00);
        rst_n = 1'b1;
        edge_n();
        chk("idle_no_req", outs(), 8'h00);

        // 1: single request, AND
        txn("t1", 1'b0, 3'd0, 3'b010, 3'b011, 1, 3'b010);
        chk("t1_pl_hold", {2'd0, o_pa, o_pb}, {2'd0, 3'b010, 3'b011});

        // 2/3: contention after reset, requester 0 wins; ack held off with req1 pending
        pulse_reset();
        chk("t2_rst_pl", {2'd0, o_pa, o_pb}, 8'h00);
        req0 = 1'b1; op0 = 3'd4; a0 = 3'b110; b0 = 3'b101;
        req1 = 1'b1; op1 = 3'd1; a1 = 3'b101; b1 = 3'b110;
        edge_n();
        chk("t2_gnt_first", {6'd0, o_g0, o_g1}, 8'b10);
        req0 = 1'b0;
        edge_n();
        chk("t2_gnt_clear", {6'd0, o_g0, o_g1}, 8'b00);
        edge_n();
        chk("t2_resp0", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011});
        for (int i = 0; i < 5; i++) begin
            edge_n();
            chk("t3_hold", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011});
        end
        resp_ack = 1'b1;
        edge_n();
        resp_ack = 1'b0;
        chk("t3_ack_idle", {5'd0, o_g1, o_v, o_oc}, 8'h00);
        edge_n();
        chk("t3_gnt1", {6'd0, o_g0, o_g1}, 8'b01);
        chk("t3_pl", {2'd0, o_pa, o_pb}, {2'd0, 3'b101, 3'b110});
        req1 = 1'b0;
        edge_n();
        edge_n();
        chk("t2_resp1", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111});
        resp_ack = 1'b1;
        edge_n();
        resp_ack = 1'b0;
        chk("t2_ack1", {6'd0, o_v, o_oc}, 8'h00);

        // 4: equality output on op 7
        txn("t4a", 1'b0, 3'd7, 3'b111, 3'b111, 1, 3'b001);
        txn("t4b", 1'b0, 3'd7, 3'b111, 3'b000, 1, 3'b000);
        // a couple of other opcodes on the same datapath
        txn("t4c", 1'b1, 3'd3, 3'b100, 3'b001, 1, 3'b010);
        txn("t4d", 1'b0, 3'd2, 3'b110, 3'b011, 1, 3'b101);

        // 5: LATENCIA=3, operand toggled during the wait
        sel3 = 1'b1;
        pulse_reset();
        req1 = 1'b1; op1 = 3'd6; a1 = 3'b101; b1 = 3'b000;
        edge_n();
        chk("t5_gnt", {6'd0, o_g0, o_g1}, 8'b01);
        req1 = 1'b0; a1 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            edge_n();
            chk("t5_wait", {5'd0, o_v, o_oc, 1'b0}, 8'b010);
            chk("t5_pl_stable", {5'd0, o_pa}, 8'b101);
            a1 = ~a1;
        end
        edge_n();
        chk("t5_resp", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010});
        resp_ack = 1'b1;
        edge_n();
        resp_ack = 1'b0;
        chk("t5_ack", {6'd0, o_v, o_oc}, 8'h00);

        // 6: reset during the wait aborts the transaction
        sel3 = 1'b0;
        pulse_reset();
        req1 = 1'b1; op1 = 3'd1; a1 = 3'b011; b1 = 3'b100;
        edge_n();
        chk("t6_gnt", {6'd0, o_g0, o_g1}, 8'b01);
        req1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_outs", outs(), 8'h00);
        chk("t6_async_pl", {2'd0, o_pa, o_pb}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_n();
            chk("t6_no_resp", outs(), 8'h00);
        end
        req0 = 1'b1; op0 = 3'd5; a0 = 3'b100; b0 = 3'b100;
        req1 = 1'b1; op1 = 3'd0; a1 = 3'b111; b1 = 3'b111;
        edge_n();
        chk("t6_rr_winner", {6'd0, o_g0, o_g1}, 8'b10);
        req0 = 1'b0; req1 = 1'b0;
        edge_n();
        edge_n();
        chk("t6_resp", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        n_err++;
        $display("FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end
endmodule
